// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// multi-cycle arbitration of the shared instruction/data memory port.
module hazard_controller #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memRead_a_IDEX,
   input  logic [2:0]  registerToWriteId_a_IDEX,
   input  logic [2:0]  Rx_a_IFID,
   input  logic [2:0]  Ry_a_IFID,
   input  logic        readRx_a_IFID,
   input  logic        readRy_a_IFID,
   input  logic        branchTaken_a_EX,
   input  logic        memAccess_a_EXMEM,
   output logic        pcEnable,
   output logic        ifidEnable,
   output logic        idexEnable,
   output logic        exmemEnable,
   output logic        memwbEnable,
   output logic        ifidFlush,
   output logic        idexFlush,
   output logic        memPortSel,
   output logic [15:0] stallCycles
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   // Counter value on entry to MEM_WAIT; access cycle 1 is spent in RUN.
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;
   localparam bit SINGLE_CYCLE = (WAIT_CYCLES == 1);

   state_t      state_reg, state_next;
   logic [3:0]  wait_cnt_reg, wait_cnt_next;
   logic [15:0] stall_cycles_reg;
   logic        load_use;
   logic        access_busy;
   logic        access_final;

   always_comb begin
      load_use = memRead_a_IDEX &&
                 ((readRx_a_IFID && (registerToWriteId_a_IDEX == Rx_a_IFID)) ||
                  (readRy_a_IFID && (registerToWriteId_a_IDEX == Ry_a_IFID)));
   end

   // Outputs react in the same cycle as the hazard, so they are combinational.
   always_comb begin
      pcEnable      = 1'b1;
      ifidEnable    = 1'b1;
      idexEnable    = 1'b1;
      exmemEnable   = 1'b1;
      memwbEnable   = 1'b1;
      ifidFlush     = 1'b0;
      idexFlush     = 1'b0;
      memPortSel    = 1'b0;
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      access_busy   = 1'b0;
      access_final  = 1'b0;

      if (rst) begin
         pcEnable      = 1'b0;
         ifidEnable    = 1'b0;
         idexEnable    = 1'b0;
         exmemEnable   = 1'b0;
         memwbEnable   = 1'b0;
         ifidFlush     = 1'b1;
         idexFlush     = 1'b1;
         state_next    = RUN;
         wait_cnt_next = 4'd0;
      end else begin
         case (state_reg)
            RUN: begin
               if (memAccess_a_EXMEM) begin
                  memPortSel = 1'b1;
                  if (SINGLE_CYCLE) begin
                     access_final = 1'b1;
                  end else begin
                     access_busy   = 1'b1;
                     state_next    = MEM_WAIT;
                     wait_cnt_next = WAIT_INIT;
                  end
               end else if (branchTaken_a_EX) begin
                  ifidFlush = 1'b1;
                  idexFlush = 1'b1;
               end else if (load_use) begin
                  pcEnable   = 1'b0;
                  ifidEnable = 1'b0;
                  idexFlush  = 1'b1;
               end
            end
            MEM_WAIT: begin
               memPortSel = 1'b1;
               if (wait_cnt_reg == 4'd0) begin
                  access_final = 1'b1;
                  state_next   = RUN;
               end else begin
                  access_busy   = 1'b1;
                  wait_cnt_next = wait_cnt_reg - 4'd1;
               end
            end
            default: begin
               state_next    = RUN;
               wait_cnt_next = 4'd0;
            end
         endcase

         if (access_busy) begin
            pcEnable    = 1'b0;
            ifidEnable  = 1'b0;
            idexEnable  = 1'b0;
            exmemEnable = 1'b0;
            memwbEnable = 1'b0;
            ifidFlush   = 1'b0;
            idexFlush   = 1'b0;
         end

         // The fetch slot was lost to the data access, so IF/ID gets a bubble
         // unless a taken branch or a pending load-use hazard overrides it.
         if (access_final) begin
            pcEnable  = 1'b0;
            ifidFlush = 1'b1;
            idexFlush = 1'b0;
            if (branchTaken_a_EX) begin
               pcEnable  = 1'b1;
               idexFlush = 1'b1;
            end else if (load_use) begin
               ifidEnable = 1'b0;
               ifidFlush  = 1'b0;
               idexFlush  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= RUN;
         wait_cnt_reg     <= 4'd0;
         stall_cycles_reg <= 16'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (!pcEnable && (stall_cycles_reg != 16'hFFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 16'd1;
         end
      end
   end

   assign stallCycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller with WAIT_CYCLES = 3, 1 and 4
// instances driven from shared stimulus.
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_read;
   logic [2:0] rd;
   logic [2:0] rx;
   logic [2:0] ry;
   logic       read_rx;
   logic       read_ry;
   logic       branch;
   logic       mem_access;

   logic [2:0] pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic [2:0] ifid_fl, idex_fl, port_sel;
   logic [15:0] stall [3];

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         hazard_controller #(
            .WAIT_CYCLES((gi == 0) ? 3 : ((gi == 1) ? 1 : 4))
         ) dut (
            .clk                      (clk),
            .rst                      (rst),
            .memRead_a_IDEX           (mem_read),
            .registerToWriteId_a_IDEX (rd),
            .Rx_a_IFID                (rx),
            .Ry_a_IFID                (ry),
            .readRx_a_IFID            (read_rx),
            .readRy_a_IFID            (read_ry),
            .branchTaken_a_EX         (branch),
            .memAccess_a_EXMEM        (mem_access),
            .pcEnable                 (pc_en[gi]),
            .ifidEnable               (ifid_en[gi]),
            .idexEnable               (idex_en[gi]),
            .exmemEnable              (exmem_en[gi]),
            .memwbEnable              (memwb_en[gi]),
            .ifidFlush                (ifid_fl[gi]),
            .idexFlush                (idex_fl[gi]),
            .memPortSel               (port_sel[gi]),
            .stallCycles              (stall[gi])
         );
      end
   endgenerate

   // Vector order: pc, ifid, idex, exmem, memwb enables, ifidFlush, idexFlush, memPortSel
   localparam logic [7:0] DEF    = 8'b11111_000;
   localparam logic [7:0] RSTV   = 8'b00000_110;
   localparam logic [7:0] LU     = 8'b00111_010;
   localparam logic [7:0] BR     = 8'b11111_110;
   localparam logic [7:0] WAITV  = 8'b00000_001;
   localparam logic [7:0] FIN    = 8'b01111_101;
   localparam logic [7:0] FIN_BR = 8'b11111_111;
   localparam logic [7:0] FIN_LU = 8'b00111_011;

   typedef struct {
      string      tag;
      int         dut;
      logic [7:0] exp;
   } item_t;

   item_t q[$];
   int    sel = 0;
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic logic [7:0] obs(int i);
      return {pc_en[i], ifid_en[i], idex_en[i], exmem_en[i], memwb_en[i],
              ifid_fl[i], idex_fl[i], port_sel[i]};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Queue the expectation with the stimulus, then pop and compare at the negedge.
   task automatic step(input string tag, input logic [7:0] exp);
      item_t it;
      q.push_back('{tag, sel, exp});
      @(negedge clk);
      it = q.pop_front();
      check(it.tag, 32'(obs(it.dut)), 32'(it.exp));
      $display("%0t dut%0d %s outputs=%b stall=%0d", $time, it.dut, it.tag,
               obs(it.dut), stall[it.dut]);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_read = 1'b0; rd = 3'd0; rx = 3'd0; ry = 3'd0;
      read_rx = 1'b0; read_ry = 1'b0; branch = 1'b0; mem_access = 1'b0;
   endtask

   task automatic set_load_use();
      mem_read = 1'b1; rd = 3'd3; rx = 3'd3; read_rx = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step("reset", RSTV);
      rst = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         step("rst_outputs", RSTV);
         check("rst_stall", 32'(stall[s]), 32'd0);
      end
      rst = 1'b0;

      // Load-use and branch decisions on the WAIT_CYCLES=3 instance
      sel = 0;
      step("first_default", DEF);
      set_load_use();
      step("load_use_rx", LU);
      idle();
      step("after_bubble", DEF);
      check("stall_after_lu", 32'(stall[0]), 32'd1);
      mem_read = 1'b1; rd = 3'd3; rx = 3'd3; ry = 3'd3;
      step("no_read_flags", DEF);
      read_ry = 1'b1; rx = 3'd5;
      step("load_use_ry", LU);
      read_ry = 1'b0; read_rx = 1'b1; rx = 3'd2;
      step("reg_mismatch", DEF);
      mem_read = 1'b0; rx = 3'd3;
      step("not_a_load", DEF);
      set_load_use(); branch = 1'b1;
      step("branch_over_lu", BR);
      check("stall_after_br", 32'(stall[0]), 32'd2);

      // WAIT_CYCLES=3 access sequences
      do_reset();
      mem_access = 1'b1;
      step("w3_acc1", WAITV);
      mem_access = 1'b0; branch = 1'b1; set_load_use();
      step("w3_acc2_ignores", WAITV);
      idle();
      step("w3_final", FIN);
      step("w3_done", DEF);
      check("w3_stall", 32'(stall[0]), 32'd3);

      mem_access = 1'b1;
      step("w3b_acc1", WAITV);
      idle();
      step("w3b_acc2", WAITV);
      branch = 1'b1;
      step("w3b_final_branch", FIN_BR);
      idle();

      mem_access = 1'b1;
      step("w3c_acc1", WAITV);
      idle();
      step("w3c_acc2", WAITV);
      set_load_use();
      step("w3c_final_lu", FIN_LU);
      idle();

      mem_access = 1'b1;
      step("b2b_a1", WAITV);
      step("b2b_a2", WAITV);
      step("b2b_a3", FIN);
      step("b2b_b1", WAITV);
      step("b2b_b2", WAITV);
      step("b2b_b3", FIN);
      mem_access = 1'b0;
      step("b2b_done", DEF);

      // WAIT_CYCLES=1
      sel = 1;
      do_reset();
      mem_access = 1'b1; branch = 1'b1;
      step("w1_acc_branch", FIN_BR);
      idle();
      step("w1_stays_run", DEF);
      mem_access = 1'b1;
      step("w1_acc", FIN);
      idle();
      check("w1_stall", 32'(stall[1]), 32'd1);

      // WAIT_CYCLES=4 with reset mid-wait
      sel = 2;
      do_reset();
      mem_access = 1'b1;
      step("w4_acc1", WAITV);
      mem_access = 1'b0;
      step("w4_wait1", WAITV);
      rst = 1'b1;
      step("w4_rst_abort", RSTV);
      rst = 1'b0;
      step("w4_after_rst", DEF);
      check("w4_stall_cleared", 32'(stall[2]), 32'd0);
      mem_access = 1'b1;
      step("w4_acc1_again", WAITV);
      mem_access = 1'b0;
      step("w4_wait1_again", WAITV);
      step("w4_wait2_again", WAITV);
      step("w4_final", FIN);
      step("w4_done", DEF);
      check("w4_stall", 32'(stall[2]), 32'd4);

      // Saturation of the stall counter
      sel = 0;
      do_reset();
      set_load_use();
      repeat (70000) @(posedge clk);
      #1;
      step("sat_lu", LU);
      check("stall_saturated", 32'(stall[0]), 32'h0000FFFF);
      idle();
      step("sat_release", DEF);
      check("stall_held", 32'(stall[0]), 32'h0000FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, is the number of cycles a data access holds the shared instruction/data memory port; the legal range is 1..15.
REQ-002 clk  in  1  is the single pipeline clock; all state updates on its rising edge.
REQ-003 rst  in  1  is the reset, synchronous and active-high.
REQ-004 memRead_a_IDEX  in  1  is set when the instruction in ID/EX is a load.
REQ-005 registerToWriteId_a_IDEX  in  3  is the destination register of the instruction in ID/EX.
REQ-006 Rx_a_IFID, Ry_a_IFID  in  3 each  are the source registers of the instruction in IF/ID.
REQ-007 readRx_a_IFID, readRy_a_IFID  in  1 each  are set when the IF/ID instruction actually reads Rx or Ry.
REQ-008 branchTaken_a_EX  in  1  is set when the branch or jump in EX resolves taken.
REQ-009 memAccess_a_EXMEM  in  1  is set when the EX/MEM instruction loads or stores through the shared memory port.
REQ-010 pcEnable, ifidEnable, idexEnable, exmemEnable, memwbEnable  out  1 each  are the PC and pipeline-register write enables.
REQ-011 ifidFlush, idexFlush  out  1 each  make IF/ID or ID/EX load a bubble on the next edge.
REQ-012 memPortSel  out  1  selects the owner of the shared memory port: 0 = fetch, 1 = data.
REQ-013 stallCycles  out  16  is a saturating count of cycles with pcEnable=0 and rst=0.

Function
REQ-014 The FSM SHALL have two states, RUN and MEM_WAIT, plus a 4-bit waitCnt.
REQ-015 Default outputs SHALL be: all enables 1, both flushes 0, memPortSel 0.
REQ-016 A load-use hazard is memRead_a_IDEX=1 and registerToWriteId_a_IDEX matching Rx_a_IFID (with readRx_a_IFID=1) or Ry_a_IFID (with readRy_a_IFID=1); on a hazard the block SHALL drive pcEnable=0, ifidEnable=0 and idexFlush=1 in that same cycle, giving a 1-cycle bubble.
REQ-017 On branchTaken_a_EX=1 the block SHALL drive ifidFlush=1, idexFlush=1 and pcEnable=1 in that same cycle; branch takes priority over load-use.
REQ-018 On memAccess_a_EXMEM=1 in RUN, that cycle is access cycle 1 and the block SHALL drive memPortSel=1.
REQ-019 If WAIT_CYCLES=1, access cycle 1 is the final cycle.
REQ-020 If WAIT_CYCLES>1, the block SHALL enter MEM_WAIT with waitCnt=WAIT_CYCLES-2 and drive all five enables to 0.
REQ-021 In MEM_WAIT the block SHALL drive memPortSel=1, decrement waitCnt each cycle, and treat waitCnt=0 as the final cycle.
REQ-022 Each non-final access cycle SHALL drive all five enables to 0, both flushes to 0, and ignore branch and load-use inputs.
REQ-023 In the final access cycle the block SHALL drive memPortSel=1, pcEnable=0, ifidFlush=1, all other enables 1, and return to RUN on the next edge.
REQ-024 In the final cycle, if branchTaken_a_EX=1, the block SHALL also drive idexFlush=1 and pcEnable=1 so the PC loads the branch target.
REQ-025 In the final cycle, if a load-use hazard exists and no branch is taken, the block SHALL drive ifidEnable=0, ifidFlush=0 and idexFlush=1.
REQ-026 memAccess_a_EXMEM is sampled only in RUN; it is not re-armed while in MEM_WAIT.
REQ-027 Back-to-back accesses in consecutive EX/MEM slots SHALL each take a full WAIT_CYCLES.
REQ-028 stallCycles SHALL increment every non-reset cycle with pcEnable=0 and hold at 16'hFFFF.

Reset
REQ-029 While rst=1: state goes to RUN, waitCnt=0, stallCycles=0; all enables 0, ifidFlush=1, idexFlush=1, memPortSel=0.
REQ-030 Assertion of rst mid-MEM_WAIT SHALL abort the access within the same cycle.
REQ-031 The first cycle after rst falls SHALL drive the default outputs.

Verification
REQ-032 Load r3 in ID/EX, IF/ID reads Rx=3 with readRx_a_IFID=1 -> one cycle of pcEnable=0, ifidEnable=0, idexFlush=1; next cycle defaults; stallCycles=1.
REQ-033 Same registers but readRx_a_IFID=0 and readRy_a_IFID=0 -> no stall.
REQ-034 WAIT_CYCLES=3, memAccess_a_EXMEM pulse in RUN -> memPortSel=1 for 3 cycles; cycles 1-2 all enables 0; cycle 3 pcEnable=0, ifidFlush=1, other enables 1; stallCycles=3.
REQ-035 WAIT_CYCLES=1, memAccess_a_EXMEM=1 and branchTaken_a_EX=1 together -> memPortSel=1, pcEnable=1, ifidFlush=1, idexFlush=1, state stays RUN.
REQ-036 WAIT_CYCLES=4, rst=1 in the 2nd MEM_WAIT cycle -> reset outputs that cycle; after rst=0, state RUN with stallCycles=0.
REQ-037 Hold pcEnable=0 for 70000 cycles -> stallCycles saturates at 16'hFFFF.
